exe_ctrl: RTL and testbench
===========================

EXE_CTRL -- requirements
Module: exe_ctrl

Interface
REQ-001 SHALL have parameter ALU_ADD, default 4'b0000, the aluop code for 64-bit add.
REQ-002 SHALL have parameter ALU_SUB, default 4'b0001, the aluop code for subtract, which drives eq_flag and signed less_flag.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have the upstream ports: id_valid  in  1  decode op valid; id_ready  out  1  controller accepts op.
REQ-005 SHALL have the op fields: id_aluop in 4; id_op1_sel in 1 (1=rs1, 0=pc); id_op2_sel in 1 (1=rs2, 0=imm); id_br_type in 3; id_rd_addr in 5; id_rd_wena in 1.
REQ-006 SHALL have the operand ports: id_rs1_data, id_rs2_data, id_imm_data, id_pc  in  64 each.
REQ-007 SHALL have the datapath drive ports: ex_aluop out 4; ex_op1 out 1; ex_op2 out 1; ex_rs1_data, ex_rs2_data, ex_imm_data, ex_pc out 64 each.
REQ-008 SHALL have the datapath return ports: ex_rd_data in 64; ex_eq_flag in 1; ex_less_flag in 1.
REQ-009 SHALL have the downstream ports: mem_valid out 1; mem_ready in 1; mem_result out 64; mem_rd_addr out 5; mem_rd_wena out 1.
REQ-010 SHALL have the redirect ports: redirect_valid out 1; redirect_pc out 64; busy out 1 (state != IDLE).

Function
REQ-011 SHALL encode id_br_type as: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JAL, 110 JALR; 111 SHALL be treated as none.
REQ-012 SHALL implement the states IDLE, EXEC, CMP, LINK, TGT and DONE.
REQ-013 SHALL drive id_ready = (state==IDLE) | (state==DONE & mem_ready); an accept occurs on a clk edge with id_valid & id_ready, and all id_* fields SHALL be latched on that edge.
REQ-014 SHALL, on accept, go to the next state by type: none -> EXEC; BEQ/BNE/BLT/BGE -> CMP; JAL/JALR -> LINK.
REQ-015 SHALL, in EXEC, drive the latched aluop, op1_sel, op2_sel and operands; at the next edge it SHALL capture ex_rd_data into mem_result and go to DONE.
REQ-016 SHALL, in CMP, drive ALU_SUB with op1=1 and op2=1, then capture the flags at the next edge. Taken is: BEQ eq; BNE !eq; BLT less; BGE !less.
REQ-017 SHALL, after CMP, go to TGT when taken and to DONE when not taken; for conditional branches mem_rd_wena SHALL be 0 and mem_result SHALL be 0.
REQ-018 SHALL, in LINK, drive ALU_ADD with op1=0, op2=0 and ex_imm_data=64'd4; it SHALL capture ex_rd_data as mem_result, set mem_rd_wena=latched id_rd_wena, and go to TGT.
REQ-019 SHALL, in TGT, drive ALU_ADD with op2=0 and the latched imm; op1=0 (pc) for branch and JAL, op1=1 (rs1) for JALR.
REQ-020 SHALL, at the edge leaving TGT, load redirect_pc = ex_rd_data (bit 0 cleared for JALR only) and go to DONE.
REQ-021 SHALL assert redirect_valid for exactly one cycle, the first cycle in DONE reached via TGT; otherwise it SHALL be 0.
REQ-022 SHALL assert mem_valid exactly while in DONE, and hold mem_result, mem_rd_addr and mem_rd_wena stable until mem_ready.
REQ-023 SHALL, in DONE with mem_ready: on a simultaneous accept, go directly to that op's first state (back-to-back, no bubble); with no accept, go to IDLE.
REQ-024 SHALL, in IDLE and DONE, drive ex_aluop=ALU_ADD, ex_op1=0, ex_op2=0 and all ex_* data=0.
REQ-025 SHALL have latency, counted in edges from accept to mem_valid high: ALU op 2; not-taken branch 2; taken branch 3; JAL/JALR 3.
REQ-026 SHALL ignore id_valid in every state except IDLE and DONE&mem_ready; upstream SHALL hold its fields while not accepted.

Reset
REQ-027 SHALL, when rst is high at an edge, force state=IDLE and mem_valid, mem_rd_wena, redirect_valid and busy to 0; mem_result, mem_rd_addr and redirect_pc SHALL be 0.
REQ-028 SHALL, on reset mid-operation (any state), discard the in-flight op with no mem_valid and no redirect_valid pulse, and make id_ready=1 on the cycle after rst deasserts.
REQ-029 SHALL give rst priority over an accept on the same edge.

Verification
REQ-030 SHALL pass a plain ALU op: aluop=ADD, rs1=5, rs2=7, op1=op2=1, rd=3, wena=1 -> mem_valid 2 edges later, mem_result=12, mem_rd_addr=3, no redirect.
REQ-031 SHALL pass a taken BLT: rs1=-1, rs2=1, pc=0x8000_0000, imm=0x10 -> redirect_valid one cycle with redirect_pc=0x8000_0010, mem_rd_wena=0, mem_valid 3 edges after accept.
REQ-032 SHALL pass a not-taken BEQ: rs1=4, rs2=5 -> no redirect, mem_valid 2 edges after accept, mem_rd_wena=0.
REQ-033 SHALL pass a JALR: rs1=0x1001, imm=0x4, pc=0x200, rd=1 -> mem_result=0x204, redirect_pc=0x1004, mem_rd_wena=1.
REQ-034 SHALL pass back-pressure and back-to-back: hold mem_ready=0 for 3 cycles -> outputs stable; then mem_ready=1 with id_valid=1 -> accept the same edge, next op in EXEC with no IDLE cycle.
REQ-035 SHALL pass reset in TGT of a taken BNE: pulse rst -> no redirect_valid, no mem_valid, state IDLE, id_ready=1.

Source files
------------

// File: rtl/exe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exe_ctrl
// Sequences ALU ops, branches and jumps through a shared external ALU.
// Revision : 1.0
// ============================================================================
module exe_ctrl #(
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [3:0]  id_aluop,
  input  logic        id_op1_sel,
  input  logic        id_op2_sel,
  input  logic [2:0]  id_br_type,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_wena,
  input  logic [63:0] id_rs1_data,
  input  logic [63:0] id_rs2_data,
  input  logic [63:0] id_imm_data,
  input  logic [63:0] id_pc,
  output logic [3:0]  ex_aluop,
  output logic        ex_op1,
  output logic        ex_op2,
  output logic [63:0] ex_rs1_data,
  output logic [63:0] ex_rs2_data,
  output logic [63:0] ex_imm_data,
  output logic [63:0] ex_pc,
  input  logic [63:0] ex_rd_data,
  input  logic        ex_eq_flag,
  input  logic        ex_less_flag,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_result,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_rd_wena,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_CMP  = 3'd2,
    S_LINK = 3'd3,
    S_TGT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [2:0] c_br_beq  = 3'd1;
  localparam logic [2:0] c_br_bne  = 3'd2;
  localparam logic [2:0] c_br_blt  = 3'd3;
  localparam logic [2:0] c_br_bge  = 3'd4;
  localparam logic [2:0] c_br_jal  = 3'd5;
  localparam logic [2:0] c_br_jalr = 3'd6;

  state_t      state_q, state_d;
  logic [3:0]  aluop_q, aluop_d;
  logic        op1_sel_q, op1_sel_d;
  logic        op2_sel_q, op2_sel_d;
  logic [2:0]  br_type_q, br_type_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        rd_wena_q, rd_wena_d;
  logic [63:0] rs1_q, rs1_d;
  logic [63:0] rs2_q, rs2_d;
  logic [63:0] imm_q, imm_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] mem_result_q, mem_result_d;
  logic        mem_rd_wena_q, mem_rd_wena_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        w_accept;
  logic        w_taken;

  function automatic state_t first_state(input logic [2:0] br);
    case (br)
      c_br_beq, c_br_bne, c_br_blt, c_br_bge: first_state = S_CMP;
      c_br_jal, c_br_jalr:                    first_state = S_LINK;
      default:                                first_state = S_EXEC;
    endcase
  endfunction

  assign id_ready       = (state_q == S_IDLE) | ((state_q == S_DONE) & mem_ready);
  assign w_accept       = id_valid & id_ready;
  assign busy           = (state_q != S_IDLE);
  assign mem_valid      = (state_q == S_DONE);
  assign mem_result     = mem_result_q;
  assign mem_rd_addr    = rd_addr_q;
  assign mem_rd_wena    = mem_rd_wena_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  always_comb begin
    w_taken = 1'b0;
    case (br_type_q)
      c_br_beq: w_taken = ex_eq_flag;
      c_br_bne: w_taken = ~ex_eq_flag;
      c_br_blt: w_taken = ex_less_flag;
      c_br_bge: w_taken = ~ex_less_flag;
      default:  w_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    aluop_d          = aluop_q;
    op1_sel_d        = op1_sel_q;
    op2_sel_d        = op2_sel_q;
    br_type_d        = br_type_q;
    rd_addr_d        = rd_addr_q;
    rd_wena_d        = rd_wena_q;
    rs1_d            = rs1_q;
    rs2_d            = rs2_q;
    imm_d            = imm_q;
    pc_d             = pc_q;
    mem_result_d     = mem_result_q;
    mem_rd_wena_d    = mem_rd_wena_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_EXEC: begin
        mem_result_d  = ex_rd_data;
        mem_rd_wena_d = rd_wena_q;
        state_d       = S_DONE;
      end
      S_CMP:  state_d = w_taken ? S_TGT : S_DONE;
      S_LINK: begin
        mem_result_d  = ex_rd_data;
        mem_rd_wena_d = rd_wena_q;
        state_d       = S_TGT;
      end
      S_TGT: begin
        redirect_pc_d    = (br_type_q == c_br_jalr) ? {ex_rd_data[63:1], 1'b0} : ex_rd_data;
        redirect_valid_d = 1'b1;
        state_d          = S_DONE;
      end
      S_DONE: if (mem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An accept only happens in IDLE or a retiring DONE, so it overrides the above.
    if (w_accept) begin
      aluop_d       = id_aluop;
      op1_sel_d     = id_op1_sel;
      op2_sel_d     = id_op2_sel;
      br_type_d     = id_br_type;
      rd_addr_d     = id_rd_addr;
      rd_wena_d     = id_rd_wena;
      rs1_d         = id_rs1_data;
      rs2_d         = id_rs2_data;
      imm_d         = id_imm_data;
      pc_d          = id_pc;
      mem_result_d  = 64'd0;
      mem_rd_wena_d = 1'b0;
      state_d       = first_state(id_br_type);
    end
  end

  always_comb begin
    ex_aluop    = ALU_ADD;
    ex_op1      = 1'b0;
    ex_op2      = 1'b0;
    ex_rs1_data = 64'd0;
    ex_rs2_data = 64'd0;
    ex_imm_data = 64'd0;
    ex_pc       = 64'd0;
    case (state_q)
      S_EXEC: begin
        ex_aluop    = aluop_q;
        ex_op1      = op1_sel_q;
        ex_op2      = op2_sel_q;
        ex_rs1_data = rs1_q;
        ex_rs2_data = rs2_q;
        ex_imm_data = imm_q;
        ex_pc       = pc_q;
      end
      S_CMP: begin
        ex_aluop    = ALU_SUB;
        ex_op1      = 1'b1;
        ex_op2      = 1'b1;
        ex_rs1_data = rs1_q;
        ex_rs2_data = rs2_q;
      end
      S_LINK: begin
        ex_imm_data = 64'd4;
        ex_pc       = pc_q;
      end
      S_TGT: begin
        ex_op1      = (br_type_q == c_br_jalr);
        ex_rs1_data = rs1_q;
        ex_imm_data = imm_q;
        ex_pc       = pc_q;
      end
      default: ex_aluop = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      aluop_q          <= 4'd0;
      op1_sel_q        <= 1'b0;
      op2_sel_q        <= 1'b0;
      br_type_q        <= 3'd0;
      rd_addr_q        <= 5'd0;
      rd_wena_q        <= 1'b0;
      rs1_q            <= 64'd0;
      rs2_q            <= 64'd0;
      imm_q            <= 64'd0;
      pc_q             <= 64'd0;
      mem_result_q     <= 64'd0;
      mem_rd_wena_q    <= 1'b0;
      redirect_pc_q    <= 64'd0;
      redirect_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      aluop_q          <= aluop_d;
      op1_sel_q        <= op1_sel_d;
      op2_sel_q        <= op2_sel_d;
      br_type_q        <= br_type_d;
      rd_addr_q        <= rd_addr_d;
      rd_wena_q        <= rd_wena_d;
      rs1_q            <= rs1_d;
      rs2_q            <= rs2_d;
      imm_q            <= imm_d;
      pc_q             <= pc_d;
      mem_result_q     <= mem_result_d;
      mem_rd_wena_q    <= mem_rd_wena_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_ctrl
// Self-checking bench for exe_ctrl with an emulated ALU and reference model.
// Revision : 1.0
// ============================================================================
module tb_exe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [3:0]  id_aluop;
  logic        id_op1_sel, id_op2_sel;
  logic [2:0]  id_br_type;
  logic [4:0]  id_rd_addr;
  logic        id_rd_wena;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm_data, id_pc;
  logic [3:0]  ex_aluop;
  logic        ex_op1, ex_op2;
  logic [63:0] ex_rs1_data, ex_rs2_data, ex_imm_data, ex_pc;
  logic [63:0] ex_rd_data;
  logic        ex_eq_flag, ex_less_flag;
  logic        mem_valid, mem_ready;
  logic [63:0] mem_result;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_wena;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_aluop), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
    .id_br_type(id_br_type), .id_rd_addr(id_rd_addr), .id_rd_wena(id_rd_wena),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm_data(id_imm_data), .id_pc(id_pc),
    .ex_aluop(ex_aluop), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm_data(ex_imm_data), .ex_pc(ex_pc),
    .ex_rd_data(ex_rd_data), .ex_eq_flag(ex_eq_flag), .ex_less_flag(ex_less_flag),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wena(mem_rd_wena),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  // Emulated datapath: 0 add, 1 subtract, anything else xor.
  function automatic logic [63:0] alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      default: alu = a ^ b;
    endcase
  endfunction

  logic [63:0] alu_a, alu_b;
  always_comb begin
    alu_a        = ex_op1 ? ex_rs1_data : ex_pc;
    alu_b        = ex_op2 ? ex_rs2_data : ex_imm_data;
    ex_rd_data   = alu(ex_aluop, alu_a, alu_b);
    ex_eq_flag   = (alu_a == alu_b);
    ex_less_flag = ($signed(alu_a) < $signed(alu_b));
  end

  typedef struct {
    logic [3:0]  aluop;
    logic        op1, op2;
    logic [2:0]  br;
    logic [4:0]  rd;
    logic        wena;
    logic [63:0] rs1, rs2, imm, pc;
    int          lat;
    logic [63:0] res;
    logic        ewena;
    logic        redir;
    logic [63:0] rpc;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] aluop, input logic op1, input logic op2,
                              input logic [2:0] br, input logic [4:0] rd, input logic wena,
                              input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic [63:0] imm, input logic [63:0] pc,
                              input int lat, input logic [63:0] res, input logic ewena,
                              input logic redir, input logic [63:0] rpc);
    vec_t v;
    v.aluop = aluop; v.op1 = op1; v.op2 = op2; v.br = br; v.rd = rd; v.wena = wena;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.lat = lat; v.res = res; v.ewena = ewena; v.redir = redir; v.rpc = rpc;
    return v;
  endfunction

  // Architectural outcome of one op, straight from the branch/jump rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic taken;
    r = v;
    r.res = 64'd0; r.ewena = 1'b0; r.redir = 1'b0; r.rpc = 64'd0;
    case (v.br)
      3'd1, 3'd2, 3'd3, 3'd4: begin
        case (v.br)
          3'd1:    taken = (v.rs1 == v.rs2);
          3'd2:    taken = (v.rs1 != v.rs2);
          3'd3:    taken = ($signed(v.rs1) < $signed(v.rs2));
          default: taken = !($signed(v.rs1) < $signed(v.rs2));
        endcase
        r.lat   = taken ? 3 : 2;
        r.redir = taken;
        r.rpc   = v.pc + v.imm;
      end
      3'd5, 3'd6: begin
        r.lat   = 3;
        r.res   = v.pc + 64'd4;
        r.ewena = v.wena;
        r.redir = 1'b1;
        r.rpc   = (v.br == 3'd5) ? v.pc + v.imm : ((v.rs1 + v.imm) & ~64'd1);
      end
      default: begin
        r.lat   = 2;
        r.res   = alu(v.aluop, v.op1 ? v.rs1 : v.pc, v.op2 ? v.rs2 : v.imm);
        r.ewena = v.wena;
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_aluop = v.aluop; id_op1_sel = v.op1; id_op2_sel = v.op2; id_br_type = v.br;
    id_rd_addr = v.rd; id_rd_wena = v.wena;
    id_rs1_data = v.rs1; id_rs2_data = v.rs2; id_imm_data = v.imm; id_pc = v.pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue from IDLE, measure latency, check results, back-pressure, then retire.
  task automatic run_op(input vec_t v, input int hold);
    int lat;
    int early;
    drive(v);
    id_valid = 1'b1;
    check("id_ready_idle", {63'd0, id_ready}, 64'd1);
    tick();
    id_valid = 1'b0;
    lat = 1;
    early = 0;
    while (!mem_valid && lat < 8) begin
      if (redirect_valid) early++;
      tick();
      lat++;
    end
    check("latency", lat, v.lat);
    check("early_redirect", early, 0);
    check("mem_valid", {63'd0, mem_valid}, 64'd1);
    check("mem_result", mem_result, v.res);
    check("mem_rd_addr", {59'd0, mem_rd_addr}, {59'd0, v.rd});
    check("mem_rd_wena", {63'd0, mem_rd_wena}, {63'd0, v.ewena});
    check("redirect_valid", {63'd0, redirect_valid}, {63'd0, v.redir});
    if (v.redir) check("redirect_pc", redirect_pc, v.rpc);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {63'd0, mem_valid}, 64'd1);
      check("hold_result", mem_result, v.res);
      check("hold_redirect", {63'd0, redirect_valid}, 64'd0);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("retire_valid", {63'd0, mem_valid}, 64'd0);
    check("retire_busy", {63'd0, busy}, 64'd0);
    check("retire_redirect", {63'd0, redirect_valid}, 64'd0);
  endtask

  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    int   cnt;

    tbl[0]  = mk(4'd0, 1, 1, 3'd0, 5'd3, 1, 64'd5, 64'd7, 64'd0, 64'd0, 2, 64'd12, 1, 0, 64'd0);
    tbl[1]  = mk(4'd0, 1, 1, 3'd3, 5'd0, 1, M1, 64'd1, 64'h10, 64'h8000_0000, 3, 64'd0, 0, 1, 64'h8000_0010);
    tbl[2]  = mk(4'd0, 1, 1, 3'd1, 5'd2, 1, 64'd4, 64'd5, 64'd0, 64'd0, 2, 64'd0, 0, 0, 64'd0);
    tbl[3]  = mk(4'd0, 1, 1, 3'd6, 5'd1, 1, 64'h1001, 64'd0, 64'h4, 64'h200, 3, 64'h204, 1, 1, 64'h1004);
    tbl[4]  = mk(4'd1, 0, 0, 3'd0, 5'd7, 0, 64'd0, 64'd0, 64'd30, 64'd100, 2, 64'd70, 0, 0, 64'd0);
    tbl[5]  = mk(4'd0, 0, 0, 3'd5, 5'd5, 1, 64'd0, 64'd0, 64'h20, 64'h1000, 3, 64'h1004, 1, 1, 64'h1020);
    tbl[6]  = mk(4'd0, 1, 1, 3'd4, 5'd8, 0, 64'd3, 64'd3, M8, 64'h40, 3, 64'd0, 0, 1, 64'h38);
    tbl[7]  = mk(4'd0, 1, 1, 3'd2, 5'd9, 1, 64'd2, 64'd2, 64'd0, 64'd0, 2, 64'd0, 0, 0, 64'd0);
    tbl[8]  = mk(4'd0, 1, 0, 3'd7, 5'd9, 1, 64'd1, 64'd99, 64'd9, 64'd0, 2, 64'd10, 1, 0, 64'd0);
    tbl[9]  = mk(4'd0, 1, 1, 3'd1, 5'd0, 0, 64'hdead, 64'hdead, 64'h11, 64'h100, 3, 64'd0, 0, 1, 64'h111);
    tbl[10] = mk(4'd0, 1, 1, 3'd3, 5'd4, 1, 64'd1, M1, 64'd8, 64'd0, 2, 64'd0, 0, 0, 64'd0);

    rst = 1'b1; id_valid = 1'b0; mem_ready = 1'b0;
    drive(tbl[0]);
    tick();
    tick();
    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check("rst_mem_result", mem_result, 64'd0);
    check("rst_mem_rd_addr", {59'd0, mem_rd_addr}, 64'd0);
    check("rst_mem_rd_wena", {63'd0, mem_rd_wena}, 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_ex_aluop", {60'd0, ex_aluop}, 64'd0);
    rst = 1'b0;
    tick();
    check("rst_id_ready", {63'd0, id_ready}, 64'd1);

    for (int i = 0; i < 11; i++) run_op(tbl[i], i % 4);

    // Back-pressure then back-to-back accept from DONE.
    drive(mk(4'd0, 1, 1, 3'd0, 5'd4, 1, 64'd1, 64'd2, 64'd0, 64'd0, 2, 64'd3, 1, 0, 64'd0));
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    tick();
    check("b2b_first_valid", {63'd0, mem_valid}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_hold_result", mem_result, 64'd3);
      check("b2b_hold_rd", {59'd0, mem_rd_addr}, 64'd4);
      check("b2b_hold_wena", {63'd0, mem_rd_wena}, 64'd1);
      check("b2b_hold_ready", {63'd0, id_ready}, 64'd0);
    end
    drive(mk(4'd1, 1, 1, 3'd0, 5'd6, 1, 64'd50, 64'd8, 64'd0, 64'd0, 2, 64'd42, 1, 0, 64'd0));
    id_valid = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("b2b_id_ready", {63'd0, id_ready}, 64'd1);
    tick();
    id_valid = 1'b0;
    mem_ready = 1'b0;
    check("b2b_no_bubble_busy", {63'd0, busy}, 64'd1);
    check("b2b_exec_aluop", {60'd0, ex_aluop}, 64'd1);
    check("b2b_exec_rs1", ex_rs1_data, 64'd50);
    tick();
    check("b2b_second_valid", {63'd0, mem_valid}, 64'd1);
    check("b2b_second_result", mem_result, 64'd42);
    check("b2b_second_rd", {59'd0, mem_rd_addr}, 64'd6);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;

    // Reset while sitting in TGT of a taken BNE.
    drive(mk(4'd0, 1, 1, 3'd2, 5'd0, 0, 64'd1, 64'd2, 64'h40, 64'h300, 3, 64'd0, 0, 1, 64'h340));
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("tgt_cmp_aluop", {60'd0, ex_aluop}, 64'd1);
    tick();
    check("tgt_busy", {63'd0, busy}, 64'd1);
    check("tgt_imm", ex_imm_data, 64'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tgt_rst_redirect", {63'd0, redirect_valid}, 64'd0);
    check("tgt_rst_valid", {63'd0, mem_valid}, 64'd0);
    check("tgt_rst_busy", {63'd0, busy}, 64'd0);
    check("tgt_rst_ready", {63'd0, id_ready}, 64'd1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_valid || redirect_valid) cnt++;
    end
    check("tgt_rst_quiet", cnt, 0);

    // Reset wins over a simultaneous accept.
    drive(tbl[0]);
    id_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id_valid = 1'b0;
    check("rst_prio_busy", {63'd0, busy}, 64'd0);
    tick();
    check("rst_prio_idle", {63'd0, busy | mem_valid}, 64'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      v.aluop = 4'($urandom_range(0, 3));
      v.op1   = 1'($urandom_range(0, 1));
      v.op2   = 1'($urandom_range(0, 1));
      v.br    = 3'($urandom_range(0, 7));
      v.rd    = 5'($urandom);
      v.wena  = 1'($urandom_range(0, 1));
      v.rs1   = {$urandom, $urandom};
      v.rs2   = ($urandom_range(0, 3) == 0) ? v.rs1 : {$urandom, $urandom};
      v.imm   = {$urandom, $urandom};
      v.pc    = {$urandom, $urandom};
      run_op(model(v), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
